sel_arb2: RTL and testbench
===========================

Name: sel_arb2

Overview:
- Two-requester round-robin arbiter that generates the select for the downstream 2:1 selector (`sel` = 0 passes `ina`, `sel` = 1 passes `inb`).
- Grants are registered and mutually exclusive.
- A burst counter caps how long one source may hold the selector while the other is waiting.
- Sits directly upstream of the selector and drives its `sel` input.

Parameters:
- MAX_BURST, 4: maximum consecutive grant cycles per source while the other source is requesting. Legal range 1..255.
- CNT_W (localparam), $clog2(MAX_BURST+1): width of the burst counter. Not overridable.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req_a  input  1  source A (selector `ina`) requests the path; level, held until done.
- req_b  input  1  source B (selector `inb`) requests the path; level, held until done.
- gnt_a  output  1  A owns the selector this cycle.
- gnt_b  output  1  B owns the selector this cycle.
- sel  output  1  select to the 2:1 selector; 1 = B, 0 = A.
- sw  output  1  one-cycle pulse in the cycle `sel` takes a new value.
- burst_cnt  output  CNT_W  cycles granted to the current owner, including the current cycle; 0 when idle.

Behaviour:
- Reset (rst_n low, asynchronous, overrides everything):
  - State = IDLE.
  - gnt_a = 0, gnt_b = 0, sel = 0, sw = 0, burst_cnt = 0.
  - Last-served pointer = B, so A wins the first tie.
  - Deassertion is sampled at the next rising clk. Reset mid-grant drops the grant immediately, with no completion.
- Output timing:
  - All outputs are registered.
  - Requests sampled at edge n are reflected in the outputs after edge n. Latency is one cycle from request to grant.
- States: IDLE, GNT_A, GNT_B.
  - gnt_a = (state == GNT_A); gnt_b = (state == GNT_B).
  - Never both high.
- IDLE:
  - Neither request: stay in IDLE. sel holds its previous value; no toggling when idle.
  - Only req_a: go to GNT_A, burst_cnt = 1.
  - Only req_b: go to GNT_B, burst_cnt = 1.
  - Both requests: grant the source that is not the last-served one, burst_cnt = 1.
- GNT_A (GNT_B is symmetric):
  - !req_a && req_b: go to GNT_B directly, with no idle bubble. burst_cnt = 1, last-served = A.
  - !req_a && !req_b: go to IDLE. burst_cnt = 0, last-served = A, sel unchanged.
  - req_a && burst_cnt < MAX_BURST: stay, burst_cnt + 1.
  - req_a && burst_cnt == MAX_BURST && req_b: preempt to GNT_B. burst_cnt = 1, last-served = A.
  - req_a && burst_cnt == MAX_BURST && !req_b: stay, burst_cnt reloads to 1. No saturation and no wrap past MAX_BURST.
- sel and sw:
  - sel = 1 while in GNT_B and 0 while in GNT_A.
  - sw = 1 for exactly the cycle after an edge where sel changed value.
- MAX_BURST = 1: with both requests held, the grant alternates A, B, A, B every cycle, and sw is high every cycle after the first grant.
- Simultaneous drop of the owner's request and rise of the other's request: handled by the direct hand-over rule above.
- Invariants:
  - burst_cnt is never 0 in a GNT state.
  - burst_cnt is never greater than MAX_BURST.

Test Plan:
1. Reset: assert rst_n = 0 mid-GNT_B, asynchronously between edges → gnt_b, sel, sw and burst_cnt read 0 before the next edge. Release reset with req_a = req_b = 1 → first grant goes to A (gnt_a = 1, sel = 0, burst_cnt = 1).
2. Single requester: req_a held 10 cycles, req_b = 0, MAX_BURST = 4 → gnt_a high all 10 cycles. burst_cnt runs 1, 2, 3, 4, 1, 2, 3, 4, 1, 2. sel = 0 throughout, sw never pulses.
3. Contention: req_a and req_b both held, MAX_BURST = 4 → grants run A×4, B×4, A×4. sel toggles at cycles 5 and 9, with a one-cycle sw pulse at each toggle.
4. Hand-over: A owns at burst_cnt = 2; in the same cycle req_a drops and req_b rises → next cycle gnt_b = 1, sel = 1, burst_cnt = 1, sw = 1. No cycle with both grants low.
5. Idle hold: B owns, then both requests drop → IDLE, burst_cnt = 0, sel stays 1, no sw pulse. Then both requests rise → A is granted (last-served = B), sel goes 0, sw pulses.
6. MAX_BURST = 1 with both requests held 6 cycles → grants run A, B, A, B, A, B. burst_cnt stays 1. sw is high every cycle after the first grant.

Source files
------------

// File: rtl/sel_arb2.sv
// Two-requester round-robin arbiter that drives the select of a downstream 2:1 selector.
// Grants are registered, mutually exclusive, and limited to MAX_BURST cycles while the other side waits.
module sel_arb2 #(
  parameter  int MAX_BURST = 4,
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic             sw,
  output logic [CNT_W-1:0] burst_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_A = 2'd1,
    S_GNT_B = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  // Request/grant protocol: req_x is a level held until the source is done;
  // gnt_x rises the cycle after req_x is sampled and the source owns the selector while gnt_x is high.
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;   // last-served source: 0 = A, 1 = B
  logic             r_sel;
  logic             r_sw;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last_nxt;
  logic             w_sel_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
      r_sw    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_sel   <= w_sel_nxt;
      r_sw    <= (w_sel_nxt != r_sel);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (req_a && (!req_b || r_last)) begin
          w_state_nxt = S_GNT_A;
          w_cnt_nxt   = ONE_CNT;
        end else if (req_b) begin
          w_state_nxt = S_GNT_B;
          w_cnt_nxt   = ONE_CNT;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      S_GNT_A: begin
        if (!req_a) begin
          w_last_nxt  = 1'b0;
          w_state_nxt = req_b ? S_GNT_B : S_IDLE;
          w_cnt_nxt   = req_b ? ONE_CNT : '0;
        end else if (r_cnt == MAX_CNT) begin
          // Burst exhausted: yield if B waits, otherwise start a fresh burst.
          w_cnt_nxt = ONE_CNT;
          if (req_b) begin
            w_state_nxt = S_GNT_B;
            w_last_nxt  = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + ONE_CNT;
        end
      end
      S_GNT_B: begin
        if (!req_b) begin
          w_last_nxt  = 1'b1;
          w_state_nxt = req_a ? S_GNT_A : S_IDLE;
          w_cnt_nxt   = req_a ? ONE_CNT : '0;
        end else if (r_cnt == MAX_CNT) begin
          w_cnt_nxt = ONE_CNT;
          if (req_a) begin
            w_state_nxt = S_GNT_A;
            w_last_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + ONE_CNT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // sel follows the owner and holds its value through idle periods.
  always_comb begin
    w_sel_nxt = r_sel;
    if (w_state_nxt == S_GNT_A) w_sel_nxt = 1'b0;
    if (w_state_nxt == S_GNT_B) w_sel_nxt = 1'b1;
  end

  always_comb begin
    gnt_a     = (r_state == S_GNT_A);
    gnt_b     = (r_state == S_GNT_B);
    sel       = r_sel;
    sw        = r_sw;
    burst_cnt = r_cnt;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_sel_arb2.sv
// Bench for sel_arb2: one instance with MAX_BURST=4 and one with MAX_BURST=1,
// directed vector tables, hand sequences and a random run against an owner/count model.
module tb_sel_arb2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ra0 = 1'b0, rb0 = 1'b0, ra1 = 1'b0, rb1 = 1'b0;
  logic       ga0, gb0, sel0, sw0, ga1, gb1, sel1, sw1;
  logic [2:0] cnt0;
  logic [0:0] cnt1;
  logic [1:0] st0, st1;

  sel_arb2 #(.MAX_BURST(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_a(ra0), .req_b(rb0),
    .gnt_a(ga0), .gnt_b(gb0), .sel(sel0), .sw(sw0), .burst_cnt(cnt0), .dbg_state(st0)
  );

  sel_arb2 #(.MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_a(ra1), .req_b(rb1),
    .gnt_a(ga1), .gnt_b(gb1), .sel(sel1), .sw(sw1), .burst_cnt(cnt1), .dbg_state(st1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner -1 = nobody, 0 = A, 1 = B.
  int m_owner[2], m_cnt[2], m_last[2], m_sel[2], m_sw[2];
  int m_max[2] = '{4, 1};

  typedef struct {
    bit rst_before;
    bit ra, rb;
    bit e_ga, e_gb, e_sel, e_sw;
    int e_cnt;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_cnt[k] = 0; m_last[k] = 1; m_sel[k] = 0; m_sw[k] = 0;
    end
  endfunction

  function automatic void model_step(input int k, input bit ra, input bit rb);
    bit want[2];
    int o, nown, ncnt, nsel;
    want[0] = ra; want[1] = rb;
    o = m_owner[k];
    if (o >= 0) begin
      if (want[o] && (m_cnt[k] < m_max[k] || !want[1-o])) begin
        nown = o; ncnt = (m_cnt[k] % m_max[k]) + 1;
      end else if (want[1-o]) begin
        nown = 1 - o; ncnt = 1;
      end else begin
        nown = -1; ncnt = 0;
      end
    end else begin
      if (ra && rb)  nown = 1 - m_last[k];
      else if (ra)   nown = 0;
      else if (rb)   nown = 1;
      else           nown = -1;
      ncnt = (nown >= 0) ? 1 : 0;
    end
    if (nown >= 0) m_last[k] = nown;
    nsel = (nown >= 0) ? nown : m_sel[k];
    m_sw[k]    = (nsel != m_sel[k]) ? 1 : 0;
    m_sel[k]   = nsel;
    m_owner[k] = nown;
    m_cnt[k]   = ncnt;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".u0.gnt_a"}, int'(ga0),  (m_owner[0] == 0) ? 1 : 0);
    chk({tag, ".u0.gnt_b"}, int'(gb0),  (m_owner[0] == 1) ? 1 : 0);
    chk({tag, ".u0.sel"},   int'(sel0), m_sel[0]);
    chk({tag, ".u0.sw"},    int'(sw0),  m_sw[0]);
    chk({tag, ".u0.cnt"},   int'(cnt0), m_cnt[0]);
    chk({tag, ".u1.gnt_a"}, int'(ga1),  (m_owner[1] == 0) ? 1 : 0);
    chk({tag, ".u1.gnt_b"}, int'(gb1),  (m_owner[1] == 1) ? 1 : 0);
    chk({tag, ".u1.sel"},   int'(sel1), m_sel[1]);
    chk({tag, ".u1.sw"},    int'(sw1),  m_sw[1]);
    chk({tag, ".u1.cnt"},   int'(cnt1), m_cnt[1]);
  endtask

  task automatic tick(input string tag, input bit a0, input bit b0, input bit a1, input bit b1);
    ra0 = a0; rb0 = b0; ra1 = a1; rb1 = b1;
    @(posedge clk);
    #1;
    model_step(0, a0, b0);
    model_step(1, a1, b1);
    check_model(tag);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ra0 = 1'b0; rb0 = 1'b0; ra1 = 1'b0; rb1 = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_model("reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a0, b0, a1, b1;

    // Single requester then contention, expected values written from the rules by hand.
    for (int i = 0; i < 10; i++)
      vecs[i] = '{rst_before: (i == 0), ra: 1, rb: 0, e_ga: 1, e_gb: 0,
                  e_sel: 0, e_sw: 0, e_cnt: (i % 4) + 1};
    for (int i = 0; i < 12; i++)
      vecs[10+i] = '{rst_before: (i == 0), ra: 1, rb: 1,
                     e_ga: ((i / 4) % 2 == 0), e_gb: ((i / 4) % 2 == 1),
                     e_sel: ((i / 4) % 2 == 1), e_sw: (i == 4 || i == 8),
                     e_cnt: (i % 4) + 1};

    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_model("por");

    for (int i = 0; i < 22; i++) begin
      if (vecs[i].rst_before) do_reset();
      tick("vec", vecs[i].ra, vecs[i].rb, 1'b0, 1'b0);
      chk($sformatf("vec%0d.gnt_a", i), int'(ga0),  int'(vecs[i].e_ga));
      chk($sformatf("vec%0d.gnt_b", i), int'(gb0),  int'(vecs[i].e_gb));
      chk($sformatf("vec%0d.sel", i),   int'(sel0), int'(vecs[i].e_sel));
      chk($sformatf("vec%0d.sw", i),    int'(sw0),  int'(vecs[i].e_sw));
      chk($sformatf("vec%0d.cnt", i),   int'(cnt0), vecs[i].e_cnt);
    end

    // Asynchronous reset in the middle of a B grant, then release with both requesting.
    do_reset();
    tick("rst_pre", 1'b0, 1'b1, 1'b0, 1'b1);
    tick("rst_pre", 1'b0, 1'b1, 1'b0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst.gnt_b", int'(gb0),  0);
    chk("async_rst.sel",   int'(sel0), 0);
    chk("async_rst.sw",    int'(sw0),  0);
    chk("async_rst.cnt",   int'(cnt0), 0);
    chk("async_rst.u1gnt", int'(gb1),  0);
    model_reset();
    ra0 = 1'b1; rb0 = 1'b1; ra1 = 1'b0; rb1 = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_step(0, 1'b1, 1'b1);
    model_step(1, 1'b0, 1'b0);
    check_model("rst_rel");
    chk("rst_rel.gnt_a", int'(ga0),  1);
    chk("rst_rel.sel",   int'(sel0), 0);
    chk("rst_rel.cnt",   int'(cnt0), 1);

    // Direct hand-over from A at count 2 to B, then idle hold and tie-break.
    do_reset();
    tick("ho", 1'b1, 1'b0, 1'b0, 1'b0);
    tick("ho", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ho.cnt2", int'(cnt0), 2);
    tick("ho", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ho.gnt_b", int'(gb0),  1);
    chk("ho.gnt_a", int'(ga0),  0);
    chk("ho.sel",   int'(sel0), 1);
    chk("ho.sw",    int'(sw0),  1);
    chk("ho.cnt",   int'(cnt0), 1);
    tick("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle.gnt_a", int'(ga0),  0);
    chk("idle.gnt_b", int'(gb0),  0);
    chk("idle.cnt",   int'(cnt0), 0);
    chk("idle.sel",   int'(sel0), 1);
    chk("idle.sw",    int'(sw0),  0);
    tick("tie", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("tie.gnt_a", int'(ga0),  1);
    chk("tie.sel",   int'(sel0), 0);
    chk("tie.sw",    int'(sw0),  1);
    chk("tie.cnt",   int'(cnt0), 1);

    // MAX_BURST = 1 instance with both requests held.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick("mb1", 1'b0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("mb1_%0d.gnt_a", i), int'(ga1),  (i % 2 == 0) ? 1 : 0);
      chk($sformatf("mb1_%0d.gnt_b", i), int'(gb1),  (i % 2 == 1) ? 1 : 0);
      chk($sformatf("mb1_%0d.cnt", i),   int'(cnt1), 1);
      chk($sformatf("mb1_%0d.sw", i),    int'(sw1),  (i > 0) ? 1 : 0);
    end

    // Random level requests with occasional resets.
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) a0 = !a0;
      if ($urandom_range(3) == 0) b0 = !b0;
      if ($urandom_range(3) == 0) a1 = !a1;
      if ($urandom_range(3) == 0) b1 = !b1;
      if ($urandom_range(149) == 0) begin
        do_reset();
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
      end
      tick("rand", a0, b0, a1, b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
